// File: rtl/memo_recorder_if.sv
// Miss/commit observation and memo-table insert channel for the memo recorder.
// master: core/table side; slave: the recorder.
interface memo_recorder_if;
    localparam int unsigned XLEN = 32;

    logic            miss_valid;
    logic [XLEN-1:0] miss_pc;
    logic [XLEN-1:0] miss_ra;
    logic [XLEN-1:0] miss_a0;
    logic [XLEN-1:0] miss_a1;

    logic            commit_valid;
    logic [XLEN-1:0] commit_next_pc;
    logic [XLEN-1:0] gpr_a0;
    logic [XLEN-1:0] gpr_a1;
    logic            impure;

    logic            ins_valid;
    logic            ins_ready;
    logic [XLEN-1:0] ins_pc;
    logic [XLEN-1:0] ins_key;
    logic [XLEN-1:0] ins_a0;
    logic [XLEN-1:0] ins_a1;
    logic [XLEN-1:0] ins_ret_pc;

    modport master (
        output miss_valid, miss_pc, miss_ra, miss_a0, miss_a1,
        output commit_valid, commit_next_pc, gpr_a0, gpr_a1, impure,
        output ins_ready,
        input  ins_valid, ins_pc, ins_key, ins_a0, ins_a1, ins_ret_pc
    );

    modport slave (
        input  miss_valid, miss_pc, miss_ra, miss_a0, miss_a1,
        input  commit_valid, commit_next_pc, gpr_a0, gpr_a1, impure,
        input  ins_ready,
        output ins_valid, ins_pc, ins_key, ins_a0, ins_a1, ins_ret_pc
    );
endinterface

// File: rtl/memo_recorder.sv
// Records a pure function call from a memo-table miss to its return and
// issues one insert (pc, key, results, return pc) to the memo table.
module memo_recorder #(
    parameter int unsigned MAX_LEN = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               memo_enable,
    memo_recorder_if.slave     bus,
    output logic               busy,
    output logic [31:0]        dbg_rec_count,
    output logic [31:0]        dbg_abort_count
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_INSERT = 2'd2
    } state_e;

    state_e           state;
    state_e           state_next;
    logic [LEN_W-1:0] len_q;

    logic [LEN_W-1:0] len_inc_c;
    logic             start_c;
    logic             abort_c;
    logic             capture_c;
    logic             xfer_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Event decode; an impure commit beats a return, a return beats the length limit
    always_comb begin
        len_inc_c = LEN_W'(len_q + LEN_W'(1));
        start_c   = 1'b0;
        abort_c   = 1'b0;
        capture_c = 1'b0;
        xfer_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                start_c = bus.miss_valid && memo_enable;
            end
            ST_RECORD: begin
                if (!memo_enable) begin
                    abort_c = 1'b1;
                end else if (bus.commit_valid) begin
                    if (bus.impure) begin
                        abort_c = 1'b1;
                    end else if (bus.commit_next_pc == bus.ins_ret_pc) begin
                        capture_c = 1'b1;
                    end else if (len_inc_c == LEN_W'(MAX_LEN)) begin
                        abort_c = 1'b1;
                    end
                end
            end
            ST_INSERT: begin
                xfer_c = bus.ins_valid && bus.ins_ready;
            end
            default: ;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start_c) state_next = ST_RECORD;
            ST_RECORD: begin
                if (abort_c)        state_next = ST_IDLE;
                else if (capture_c) state_next = ST_INSERT;
            end
            ST_INSERT: if (xfer_c)  state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // Registered outputs and datapath; latched pc/key/ret live directly in the payload regs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q           <= '0;
            busy            <= 1'b0;
            bus.ins_valid   <= 1'b0;
            bus.ins_pc      <= '0;
            bus.ins_key     <= '0;
            bus.ins_a0      <= '0;
            bus.ins_a1      <= '0;
            bus.ins_ret_pc  <= '0;
            dbg_rec_count   <= '0;
            dbg_abort_count <= '0;
        end else begin
            busy          <= (state_next != ST_IDLE);
            bus.ins_valid <= (state_next == ST_INSERT);
            if (start_c) begin
                bus.ins_pc     <= bus.miss_pc;
                bus.ins_ret_pc <= bus.miss_ra;
                bus.ins_key    <= bus.miss_ra ^ bus.miss_a0 ^ bus.miss_a1;
                len_q          <= '0;
            end
            if (state == ST_RECORD && bus.commit_valid) begin
                len_q <= len_inc_c;
            end
            if (capture_c) begin
                bus.ins_a0 <= bus.gpr_a0;
                bus.ins_a1 <= bus.gpr_a1;
            end
            if (xfer_c) begin
                dbg_rec_count <= dbg_rec_count + 32'd1;
            end
            if (abort_c) begin
                dbg_abort_count <= dbg_abort_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_memo_recorder.sv
// Scenario-level randomized bench for memo_recorder: each recording's outcome
// is predicted from its commit list and checked against the insert channel and counters.
module tb_memo_recorder;
    localparam int unsigned MAX_LEN = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memo_enable;
    logic        busy;
    logic [31:0] rec_count;
    logic [31:0] abort_count;

    memo_recorder_if bus ();

    memo_recorder #(.MAX_LEN(MAX_LEN)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .memo_enable    (memo_enable),
        .bus            (bus),
        .busy           (busy),
        .dbg_rec_count  (rec_count),
        .dbg_abort_count(abort_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_rec  = 0;
    int exp_abort = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        bus.miss_valid     = 1'b0;
        bus.miss_pc        = $urandom;
        bus.miss_ra        = $urandom;
        bus.miss_a0        = $urandom;
        bus.miss_a1        = $urandom;
        bus.commit_valid   = 1'b0;
        bus.impure         = 1'(($urandom_range(0, 1)));
        bus.commit_next_pc = $urandom;
        bus.gpr_a0         = $urandom;
        bus.gpr_a1         = $urandom;
        bus.ins_ready      = 1'(($urandom_range(0, 1)));
    endtask

    task automatic check_idle_counts(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ins_valid"}, 32'(bus.ins_valid), 32'd0);
        check({tag, "_rec_count"}, rec_count, 32'(exp_rec));
        check({tag, "_abort_count"}, abort_count, 32'(exp_abort));
    endtask

    task automatic check_payload(input string tag, input logic [31:0] pc, key, a0, a1, ret);
        check({tag, "_ins_valid"}, 32'(bus.ins_valid), 32'd1);
        check({tag, "_pc"}, bus.ins_pc, pc);
        check({tag, "_key"}, bus.ins_key, key);
        check({tag, "_a0"}, bus.ins_a0, a0);
        check({tag, "_a1"}, bus.ins_a1, a1);
        check({tag, "_ret"}, bus.ins_ret_pc, ret);
    endtask

    // One recording: outcome is the first of enable-drop / impure / return / length limit
    task automatic record(input logic [31:0] pc, ra, a0, a1,
                          input int ret_at, impure_at, drop_at, ready_delay,
                          input logic [31:0] r_a0, r_a1,
                          input bit stray, input bit reset_mid);
        logic [31:0] key;
        bit          done;
        bit          is_ret;
        key  = ra ^ a0 ^ a1;
        done = 1'b0;
        quiet_inputs();
        memo_enable    = 1'b1;
        bus.miss_valid = 1'b1;
        bus.miss_pc    = pc;
        bus.miss_ra    = ra;
        bus.miss_a0    = a0;
        bus.miss_a1    = a1;
        step();
        quiet_inputs();
        check("rec_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= int'(MAX_LEN) && !done; k++) begin
            if (drop_at == k || (stray && k == 2) || $urandom_range(0, 2) == 0) begin
                quiet_inputs();
                if (drop_at == k) memo_enable = 1'b0;
                if (stray && k == 2) begin
                    bus.miss_valid = 1'b1;
                    bus.miss_pc    = pc ^ 32'h0000_0100;
                    bus.miss_ra    = ra ^ 32'h0000_0040;
                    bus.miss_a0    = a0 + 32'd7;
                end
                step();
                memo_enable = 1'b1;
                quiet_inputs();
                if (drop_at == k) begin
                    done = 1'b1;
                    exp_abort++;
                    check_idle_counts("drop");
                end else begin
                    check("gap_busy", 32'(busy), 32'd1);
                end
            end
            if (!done) begin
                is_ret             = (ret_at == k);
                bus.commit_valid   = 1'b1;
                bus.impure         = (impure_at == k);
                bus.commit_next_pc = is_ret ? ra : (ra ^ (32'h4 << $urandom_range(0, 3)));
                if (is_ret) begin
                    bus.gpr_a0 = r_a0;
                    bus.gpr_a1 = r_a1;
                end
                step();
                quiet_inputs();
                if (impure_at == k || (!is_ret && k == int'(MAX_LEN))) begin
                    done = 1'b1;
                    exp_abort++;
                    check_idle_counts("abort");
                end else if (is_ret) begin
                    done = 1'b1;
                    check_payload("ins_first", pc, key, r_a0, r_a1, ra);
                    bus.ins_ready = 1'b0;
                    if (reset_mid) begin
                        #2 rst_n = 1'b0;
                        #1;
                        exp_rec   = 0;
                        exp_abort = 0;
                        check_idle_counts("rst_mid");
                        check("rst_mid_pc", bus.ins_pc, 32'd0);
                        @(negedge clk);
                        rst_n = 1'b1;
                    end else begin
                        for (int d = 0; d < ready_delay; d++) begin
                            bus.ins_ready    = 1'b0;
                            memo_enable      = 1'(($urandom_range(0, 1)));
                            bus.miss_valid   = 1'(($urandom_range(0, 1)));
                            bus.commit_valid = 1'(($urandom_range(0, 1)));
                            step();
                            check("hold_busy", 32'(busy), 32'd1);
                            check_payload("hold", pc, key, r_a0, r_a1, ra);
                        end
                        quiet_inputs();
                        memo_enable    = 1'b1;
                        bus.ins_ready  = 1'b1;
                        bus.miss_valid = 1'b1;
                        step();
                        exp_rec++;
                        quiet_inputs();
                        bus.ins_ready = 1'b0;
                        check_idle_counts("xfer");
                    end
                end else begin
                    check("mid_busy", 32'(busy), 32'd1);
                    check("mid_ins_valid", 32'(bus.ins_valid), 32'd0);
                end
            end
        end
    endtask

    initial begin
        int ret_at, impure_at, drop_at;
        quiet_inputs();
        memo_enable = 1'b1;
        rst_n       = 1'b0;
        repeat (2) step();
        check_idle_counts("reset");
        check("reset_key", bus.ins_key, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Hit path with back-pressure, then a single-cycle transfer
        record(32'h1000, 32'h2000, 32'd5, 32'd0, 3, 0, 0, 2, 32'd12, 32'd0, 1'b0, 1'b0);
        record(32'h3000, 32'h4000, 32'd3, 32'd9, 1, 0, 0, 0, 32'd42, 32'd77, 1'b0, 1'b0);
        // Impure abort, and impure together with the return
        record(32'h1000, 32'h2000, 32'd5, 32'd0, 0, 2, 0, 0, 32'd0, 32'd0, 1'b0, 1'b0);
        record(32'h1000, 32'h2000, 32'd5, 32'd0, 2, 2, 0, 0, 32'd1, 32'd2, 1'b0, 1'b0);
        // Length limit without and with return on the last commit
        record(32'h5000, 32'h6000, 32'd1, 32'd1, 0, 0, 0, 0, 32'd0, 32'd0, 1'b0, 1'b0);
        record(32'h5000, 32'h6000, 32'd1, 32'd1, 4, 0, 0, 1, 32'h55, 32'h66, 1'b0, 1'b0);
        // Stray miss during recording, enable drop
        record(32'h7000, 32'h8000, 32'd2, 32'd4, 3, 0, 0, 0, 32'h77, 32'h88, 1'b1, 1'b0);
        record(32'h9000, 32'hA000, 32'd6, 32'd7, 3, 0, 2, 0, 32'd0, 32'd0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ret_at    = $urandom_range(0, 2) == 0 ? 0 : int'($urandom_range(1, MAX_LEN));
            impure_at = $urandom_range(0, 2) == 0 ? int'($urandom_range(1, MAX_LEN)) : 0;
            drop_at   = $urandom_range(0, 4) == 0 ? int'($urandom_range(1, MAX_LEN)) : 0;
            record($urandom, $urandom, $urandom, $urandom, ret_at, impure_at, drop_at,
                   int'($urandom_range(0, 3)), $urandom, $urandom,
                   1'(($urandom_range(0, 3) == 0)), 1'b0);
        end

        // Reset while an insert is stalled, then a clean recording afterwards
        record(32'h1000, 32'h2000, 32'd5, 32'd0, 2, 0, 0, 0, 32'd3, 32'd4, 1'b0, 1'b1);
        record(32'hB000, 32'hC000, 32'd1, 32'd2, 2, 0, 0, 1, 32'd9, 32'd8, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/memo_recorder.md
MEMO_RECORDER -- requirements
Module: memo_recorder

Interface
REQ-001 Parameter: MAX_LEN, default 256, maximum number of retired instructions per recording before it is abandoned.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 memo_enable  input  1  recording permitted while high.
REQ-005 miss_valid  input  1  one-cycle pulse: memo lookup missed at a candidate function entry.
REQ-006 miss_pc, miss_ra, miss_a0, miss_a1  input  32 each  entry PC and ra/a0/a1 at the miss.
REQ-007 commit_valid  input  1  one instruction retired this cycle.
REQ-008 commit_next_pc  input  32  PC following the retired instruction.
REQ-009 gpr_a0, gpr_a1  input  32 each  architectural a0/a1, including all commits before this cycle.
REQ-010 impure  input  1  retiring instruction has a side effect (store, CSR, ecall); valid only with commit_valid.
REQ-011 ins_valid  output  1  insert request to memo table.
REQ-012 ins_ready  input  1  memo table accepts insert.
REQ-013 ins_pc, ins_key, ins_a0, ins_a1, ins_ret_pc  output  32 each  insert payload.
REQ-014 busy  output  1  high when not IDLE.
REQ-015 dbg_rec_count, dbg_abort_count  output  32 each  completed inserts / abandoned recordings.

Function
REQ-016 FSM states: IDLE, RECORD, INSERT.
REQ-017 IDLE: miss_valid && memo_enable latches pc=miss_pc, ret=miss_ra, key=miss_ra^miss_a0^miss_a1 (32-bit XOR, matching the lookup hash); clears length counter; next state RECORD.
REQ-018 RECORD, per commit_valid: length counter increments by 1.
REQ-019 RECORD: commit_valid && impure -> IDLE, dbg_abort_count+1, no insert.
REQ-020 RECORD: memo_enable low in any cycle -> IDLE, dbg_abort_count+1.
REQ-021 RECORD: commit_valid with incremented length == MAX_LEN and no return -> IDLE, dbg_abort_count+1.
REQ-022 RECORD: commit_valid && !impure && commit_next_pc == latched ret -> capture gpr_a0/gpr_a1 this cycle; next state INSERT.
REQ-023 Simultaneous return and impure on one commit: abort wins.
REQ-024 Return on the MAX_LEN-th commit: return wins, insert proceeds.
REQ-025 miss_valid outside IDLE is ignored; no nesting, no counter change.
REQ-026 INSERT: ins_valid=1; ins_pc=latched pc, ins_key=key, ins_a0/ins_a1=captured, ins_ret_pc=ret; payload stable while ins_valid && !ins_ready.
REQ-027 Transfer occurs on ins_valid && ins_ready at a rising edge: dbg_rec_count+1, next state IDLE, ins_valid=0 next cycle.
REQ-028 INSERT ignores memo_enable, commits and miss_valid; it cannot be aborted except by reset.
REQ-029 ins_valid registered; first asserted the cycle after the return commit (1-cycle latency); never depends combinationally on ins_ready.
REQ-030 A new recording may start in the cycle after a transfer, not in the transfer cycle.
REQ-031 Counters are 32-bit, wrap modulo 2^32.
REQ-032 busy = (state != IDLE), registered from state.

Reset
REQ-033 rst_n low forces IDLE immediately, independent of clk; recording in progress discarded.
REQ-034 Reset values: ins_valid=0, busy=0, all payload outputs=0, dbg_rec_count=0, dbg_abort_count=0, length counter=0.
REQ-035 Reset release takes effect on first rising clk edge with rst_n high; no output glitch to 1 during reset.

Verification
REQ-036 Hit path: miss pc=0x1000, ra=0x2000, a0=5, a1=0; 3 commits, third next_pc=0x2000 with gpr_a0=12, gpr_a1=0; ins_ready low 2 cycles -> ins_valid next cycle, pc=0x1000, key=0x2005, a0=12, ret=0x2000, payload held; after ready, dbg_rec_count=1, busy=0.
REQ-037 Second key: miss pc=0x3000, ra=0x4000, a0=3, a1=9; return with a0=42, a1=77, ins_ready=1 -> single-cycle transfer, key=0x400A, a0=42, a1=77, dbg_rec_count increments by 1.
REQ-038 Impure abort: recording at pc=0x1000, commit 2 with impure=1 -> no ins_valid, dbg_abort_count=1, state IDLE; impure asserted together with return next_pc -> also abort.
REQ-039 Length limit: MAX_LEN=4, 4 non-returning commits -> abort, dbg_abort_count+1; with return on commit 4 -> insert issued.
REQ-040 Ignored miss: miss_valid pulse during RECORD with different pc -> original pc/key inserted, no extra recording.
REQ-041 Reset mid-INSERT: rst_n low while ins_valid=1, ins_ready=0 -> ins_valid=0 before next clk edge, counters 0, later miss starts cleanly.
